// File: rtl/overlay_v1_0_seq.sv
// Frame sequencer for the overlay pipeline: gates the input video stream, tracks
// pixel position against latched geometry, and regenerates SOF/EOL and the logo qualifier.
module overlay_v1_0_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic                  run,
    input  logic                  reset,
    output logic                  done,
    input  logic                  logo_valid,
    input  logic [DATA_WIDTH-1:0] width,
    input  logic [DATA_WIDTH-1:0] heigth,
    input  logic [DATA_WIDTH-1:0] logo_hlocation_begin,
    input  logic [DATA_WIDTH-1:0] logo_hlocation_end,
    input  logic [DATA_WIDTH-1:0] logo_vlocation_begin,
    input  logic [DATA_WIDTH-1:0] logo_vlocation_end,
    output logic [DATA_WIDTH-1:0] hlocation,
    output logic [DATA_WIDTH-1:0] vlocation,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  logo_active,
    output logic [1:0]            err,
    output logic [1:0]            seq_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and ready may depend on valid/tuser.

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_DONE     = 2'd3
    } seq_state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    seq_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] v_q, v_d;
    logic [1:0]            err_q, err_d;
    logic                  latch;

    logic [DATA_WIDTH-1:0] w_m1_q, h_m1_q;
    logic [DATA_WIDTH-1:0] hb_q, he_q, vb_q, ve_q;

    logic                  beat;
    logic                  sof_restart;
    logic [DATA_WIDTH-1:0] pos_h, pos_v;
    logic                  at_eol, at_eof, in_window;

    // Position of the beat currently presented; an SOF beat always counts as (0,0).
    assign sof_restart = (state_q == ST_WAIT_SOF) ||
                         ((state_q == ST_ACTIVE) && s_axis_tvalid && s_axis_tuser &&
                          ((h_q != '0) || (v_q != '0)));
    assign pos_h     = sof_restart ? '0 : h_q;
    assign pos_v     = sof_restart ? '0 : v_q;
    assign at_eol    = (pos_h == w_m1_q);
    assign at_eof    = at_eol && (pos_v == h_m1_q);
    assign in_window = logo_valid &&
                       (pos_h >= hb_q) && (pos_h <= he_q) &&
                       (pos_v >= vb_q) && (pos_v <= ve_q);
    assign beat      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        err_d         = err_q;
        latch         = 1'b0;
        done          = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        logo_active   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run && (width != '0) && (heigth != '0)) begin
                    latch   = 1'b1;
                    state_d = ST_WAIT_SOF;
                end
            end

            ST_WAIT_SOF: begin
                s_axis_tready = s_axis_tuser ? m_axis_tready : 1'b1;
                m_axis_tvalid = s_axis_tvalid && s_axis_tuser;
                if (s_axis_tvalid && s_axis_tuser) begin
                    m_axis_tuser = 1'b1;
                    m_axis_tlast = at_eol;
                    logo_active  = in_window;
                end
                if (beat && s_axis_tuser) begin
                    if (at_eof) begin
                        h_d     = '0;
                        v_d     = '0;
                        state_d = ST_DONE;
                    end else if (at_eol) begin
                        h_d     = '0;
                        v_d     = pos_v + ONE;
                        state_d = ST_ACTIVE;
                    end else begin
                        h_d     = pos_h + ONE;
                        v_d     = pos_v;
                        state_d = ST_ACTIVE;
                    end
                end
            end

            ST_ACTIVE: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tuser  = (pos_h == '0) && (pos_v == '0);
                m_axis_tlast  = at_eol;
                logo_active   = in_window;
                if (beat) begin
                    // Counting follows geometry only; tlast/tuser anomalies are just flagged.
                    if (s_axis_tlast != at_eol) err_d[0] = 1'b1;
                    if (sof_restart)            err_d[1] = 1'b1;
                    if (at_eof) begin
                        h_d     = '0;
                        v_d     = '0;
                        state_d = ST_DONE;
                    end else if (at_eol) begin
                        h_d = '0;
                        v_d = pos_v + ONE;
                    end else begin
                        h_d = pos_h + ONE;
                        v_d = pos_v;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                h_d     = '0;
                v_d     = '0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Soft reset behaves like IDLE for the whole cycle it is held.
        if (reset) begin
            state_d       = ST_IDLE;
            h_d           = '0;
            v_d           = '0;
            err_d         = 2'b00;
            latch         = 1'b0;
            done          = 1'b0;
            s_axis_tready = 1'b0;
            m_axis_tvalid = 1'b0;
            m_axis_tuser  = 1'b0;
            m_axis_tlast  = 1'b0;
            logo_active   = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            err_q   <= err_d;
        end
    end

    // Geometry is captured once per frame so register writes mid-frame have no effect.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_m1_q <= '0;
            h_m1_q <= '0;
            hb_q   <= '0;
            he_q   <= '0;
            vb_q   <= '0;
            ve_q   <= '0;
        end else if (latch) begin
            w_m1_q <= width - ONE;
            h_m1_q <= heigth - ONE;
            hb_q   <= logo_hlocation_begin;
            he_q   <= logo_hlocation_end;
            vb_q   <= logo_vlocation_begin;
            ve_q   <= logo_vlocation_end;
        end
    end

    assign hlocation = h_q;
    assign vlocation = v_q;
    assign err       = err_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_overlay_v1_0_seq.sv
// Directed bench for overlay_v1_0_seq: a position model fills an expected queue as
// beats are driven, and a negedge monitor pops and compares each accepted beat.
module tb_overlay_v1_0_seq;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run, soft_reset, done, logo_valid;
    logic [DW-1:0] width, heigth, lhb, lhe, lvb, lve, hlocation, vlocation;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic          logo_active;
    logic [1:0]    err, seq_state;

    int checks = 0;
    int errors = 0;
    int fwd_cnt = 0;
    int logo_cnt = 0;
    int fwd_base, logo_base;

    logic [3:0]    exp_q[$];
    logic [3:0]    sb_e;

    logic [DW-1:0] mw, mht, mhb, mhe, mvb, mve, mh, mv;
    logic          mlogo;
    logic          m_in_frame;
    logic [1:0]    exp_err;

    overlay_v1_0_seq #(.DATA_WIDTH(DW)) dut (
        .S_AXI_ACLK           (clk),
        .S_AXI_ARESETN        (rst_n),
        .run                  (run),
        .reset                (soft_reset),
        .done                 (done),
        .logo_valid           (logo_valid),
        .width                (width),
        .heigth               (heigth),
        .logo_hlocation_begin (lhb),
        .logo_hlocation_end   (lhe),
        .logo_vlocation_begin (lvb),
        .logo_vlocation_end   (lve),
        .hlocation            (hlocation),
        .vlocation            (vlocation),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tready        (s_axis_tready),
        .s_axis_tuser         (s_axis_tuser),
        .s_axis_tlast         (s_axis_tlast),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tuser         (m_axis_tuser),
        .m_axis_tlast         (m_axis_tlast),
        .logo_active          (logo_active),
        .err                  (err),
        .seq_state            (seq_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && s_axis_tvalid && s_axis_tready) begin
            check("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                sb_e = exp_q.pop_front();
                check("sb_beat{tvalid,tuser,tlast,logo}",
                      32'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, logo_active}), 32'(sb_e));
            end
            if (m_axis_tvalid) fwd_cnt++;
            if (logo_active) logo_cnt++;
        end
    end

    task automatic set_geom(input int w, input int h, input int hb, input int he,
                            input int vb, input int ve, input logic lv);
        width = DW'(w);  heigth = DW'(h);
        lhb = DW'(hb);   lhe = DW'(he);
        lvb = DW'(vb);   lve = DW'(ve);
        logo_valid = lv;
        mw = DW'(w);  mht = DW'(h);
        mhb = DW'(hb); mhe = DW'(he);
        mvb = DW'(vb); mve = DW'(ve);
        mlogo = lv;
    endtask

    task automatic model_abort();
        exp_q.delete();
        m_in_frame = 1'b0;
        mh = '0;
        mv = '0;
        exp_err = 2'b00;
    endtask

    task automatic drive_beat(input logic tu, input logic tl);
        logic [DW-1:0] ph, pv;
        logic fwd, e_tu, e_tl, e_lg;
        fwd = 1'b0; ph = '0; pv = '0;
        if (!m_in_frame) begin
            if (tu) begin
                fwd = 1'b1;
                m_in_frame = 1'b1;
            end
        end else begin
            fwd = 1'b1;
            if (tu && (mh != 0 || mv != 0)) exp_err[1] = 1'b1;
            else begin
                ph = mh;
                pv = mv;
            end
        end
        e_tu = 1'b0; e_tl = 1'b0; e_lg = 1'b0;
        if (fwd) begin
            e_tu = (ph == 0) && (pv == 0);
            e_tl = (ph == mw - 1);
            e_lg = mlogo && (ph >= mhb) && (ph <= mhe) && (pv >= mvb) && (pv <= mve);
            if (tl != e_tl) exp_err[0] = 1'b1;
            if (e_tl && (pv == mht - 1)) begin
                mh = '0; mv = '0; m_in_frame = 1'b0;
            end else if (e_tl) begin
                mh = '0; mv = pv + 1;
            end else begin
                mh = ph + 1; mv = pv;
            end
        end
        exp_q.push_back({fwd, e_tu, e_tl, e_lg});
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = tu;
        s_axis_tlast  = tl;
    endtask

    task automatic wait_accept();
        int n;
        logic acc;
        n = 0;
        @(negedge clk);
        acc = s_axis_tvalid && s_axis_tready;
        while (!acc && n < 50) begin
            n++;
            @(negedge clk);
            acc = s_axis_tvalid && s_axis_tready;
        end
        check("beat_accepted", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        check("hlocation", hlocation, mh);
        check("vlocation", vlocation, mv);
    endtask

    task automatic send(input logic tu, input logic tl);
        drive_beat(tu, tl);
        wait_accept();
    endtask

    task automatic send_frame();
        for (int i = 0; i < int'(mw * mht); i++)
            send(i == 0, (i % int'(mw)) == int'(mw) - 1);
    endtask

    task automatic finish_frame(input int nfwd);
        check("done_pulse", 32'(done), 32'd1);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(seq_state), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("fwd_count", 32'(fwd_cnt - fwd_base), 32'(nfwd));
        check("err", 32'(err), 32'(exp_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
        check({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        check({tag, "_m_tuser"},  32'(m_axis_tuser), 32'd0);
        check({tag, "_m_tlast"},  32'(m_axis_tlast), 32'd0);
        check({tag, "_logo"},     32'(logo_active), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
        check({tag, "_hloc"},     hlocation, 32'd0);
        check({tag, "_vloc"},     vlocation, 32'd0);
        check({tag, "_err"},      32'(err), 32'd0);
        check({tag, "_state"},    32'(seq_state), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        run = 1'b0; soft_reset = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        set_geom(0, 0, 0, 0, 0, 0, 1'b0);
        model_abort();
        #3;
        check_all_zero("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Zero width must not start a frame.
        set_geom(0, 2, 0, 0, 0, 0, 1'b0);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("zero_width_idle", 32'(seq_state), 32'd0);
        check("zero_width_tready", 32'(s_axis_tready), 32'd0);
        run = 1'b0;

        // 4x2 frame with logo window h1..2, v1..1.
        set_geom(4, 2, 1, 2, 1, 1, 1'b1);
        fwd_base = fwd_cnt; logo_base = logo_cnt;
        run = 1'b1;
        send_frame();
        finish_frame(8);
        check("logo_beats", 32'(logo_cnt - logo_base), 32'd2);

        // Three non-SOF beats are swallowed before the frame.
        set_geom(4, 2, 0, 0, 0, 0, 1'b0);
        fwd_base = fwd_cnt;
        run = 1'b1;
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        check("wait_sof_state", 32'(seq_state), 32'd1);
        send_frame();
        finish_frame(8);

        // Downstream stall on beat 2.
        fwd_base = fwd_cnt;
        run = 1'b1;
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        drive_beat(1'b0, 1'b0);
        m_axis_tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_s_tready", 32'(s_axis_tready), 32'd0);
            check("stall_hloc", hlocation, 32'd2);
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_accept();
        for (int i = 3; i < 8; i++) send(1'b0, (i % 4) == 3);
        finish_frame(8);

        // Stray tlast on beat 2, mid-frame SOF on beat 5, then soft reset.
        run = 1'b1;
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("err_both", 32'(err), 32'(exp_err));
        check("err_both_value", 32'(err), 32'd3);
        soft_reset = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        soft_reset = 1'b0;
        model_abort();
        check("soft_reset_state", 32'(seq_state), 32'd0);
        check("soft_reset_err", 32'(err), 32'd0);
        check("soft_reset_hloc", hlocation, 32'd0);
        check("soft_reset_vloc", vlocation, 32'd0);

        // Async reset while beat 4 is being presented.
        run = 1'b1;
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b1);
        s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        s_axis_tvalid = 1'b0;
        model_abort();
        @(posedge clk); #1;
        rst_n = 1'b1;
        fwd_base = fwd_cnt;
        send_frame();
        finish_frame(8);

        // Single-column frame: every pixel is end of line.
        set_geom(1, 2, 0, 0, 1, 1, 1'b1);
        fwd_base = fwd_cnt; logo_base = logo_cnt;
        run = 1'b1;
        send_frame();
        finish_frame(2);
        check("w1_logo_beats", 32'(logo_cnt - logo_base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlay_v1_0_seq.md
Name: overlay_v1_0_seq
Overview:
Frame sequencer for the overlay pipeline; sits between the AXI-Lite control block and the pixel datapath.
Gates the input video AXI-Stream and counts pixel position against the programmed geometry. Generates SOF/EOL sideband and the logo-window qualifier, and pulses done at end of frame. TDATA bypasses this block; only handshake and sideband pass through it.
Parameters:
DATA_WIDTH, 32, width of geometry, location and counter buses (matches control register width)
Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
run  in  1  start/continue request from control_reg[0]
reset  in  1  synchronous soft reset from control_reg[1]
done  out  1  one-cycle pulse at end of frame
logo_valid  in  1  logo overlay enable
width  in  DATA_WIDTH  pixels per line
heigth  in  DATA_WIDTH  lines per frame
logo_hlocation_begin / logo_hlocation_end  in  DATA_WIDTH each  logo column bounds, inclusive
logo_vlocation_begin / logo_vlocation_end  in  DATA_WIDTH each  logo line bounds, inclusive
hlocation  out  DATA_WIDTH  column of the next pixel
vlocation  out  DATA_WIDTH  line of the next pixel
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input pixel ready
s_axis_tuser  in  1  input start-of-frame
s_axis_tlast  in  1  input end-of-line
m_axis_tvalid  out  1  output pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tuser  out  1  regenerated SOF: (h==0 && v==0) in ACTIVE
m_axis_tlast  out  1  regenerated EOL: (h==W-1) in ACTIVE
logo_active  out  1  current beat lies inside the logo window
err  out  2  sticky; [0] tlast mismatch, [1] unexpected mid-frame SOF
Behaviour:
- Async reset: state IDLE; h, v, err, done = 0; all outputs 0.
- beat = s_axis_tvalid & s_axis_tready. h/v and state update only on a beat, except where a transition is stated otherwise.
- Soft reset has priority over everything except async reset: while reset=1, force IDLE, h=v=0, done=0, err=0.
- Counters: hlocation=h, vlocation=v.
- IDLE: s_axis_tready=0, m_axis_tvalid=0.
  - Leaves when run=1, width!=0 and heigth!=0: latch W, H and the four logo bounds into shadow registers, then go to WAIT_SOF.
  - With run=1 and width=0 or heigth=0: stay in IDLE.
  - Mid-frame input changes are ignored until the next latch.
- WAIT_SOF: beats without tuser are discarded.
  - s_axis_tready = s_axis_tuser ? m_axis_tready : 1.
  - m_axis_tvalid = s_axis_tvalid & s_axis_tuser.
  - A beat with tuser=1 is pixel (0,0). Forward it and go to ACTIVE with h=1, or h=0 and v=1 if W==1.
- ACTIVE: s_axis_tready=m_axis_tready; m_axis_tvalid=s_axis_tvalid.
  - On a beat: if h==W-1 then h=0 and v=v+1, else h=h+1.
  - Beat with h==W-1 and v==H-1: go to DONE.
- DONE: one cycle. done=1, s_axis_tready=0, h=v=0, then IDLE.
  - If run is still 1 in IDLE, the next frame starts (continuous mode).
  - The control block clears run on done; this is the normal path.
- tlast mismatch: s_axis_tlast != (h==W-1) on an ACTIVE beat sets err[0]. Counting continues by geometry; tlast is not used to resync.
- Mid-frame SOF: tuser=1 on an ACTIVE beat with (h,v)!=(0,0) sets err[1]. Treat the beat as pixel (0,0): h=1 (or h=0, v=1 if W==1).
- logo_active = logo_valid & hb<=h<=he & vb<=v<=ve, using shadow bounds and current h/v.
  - Unsigned compares; evaluated in ACTIVE and on the WAIT_SOF SOF beat; 0 otherwise.
  - Combinational; aligns with the beat being presented.
- Backpressure: m_axis_tready=0 stalls the input and holds counters and state. No beat is ever dropped in ACTIVE.
- Arithmetic: DATA_WIDTH unsigned throughout. W-1 and H-1 are computed once at latch. No counter exceeds W-1 / H-1.
Test Plan:
- W=4, H=2, run=1, continuous valid/ready, tuser on beat 0, tlast on beats 3 and 7 -> 8 beats forwarded; m_axis_tlast on beats 3 and 7; m_axis_tuser on beat 0 only; done pulses 1 cycle after beat 7; err=0.
- Logo bounds h 1..2, v 1..1, logo_valid=1, same frame -> logo_active=1 exactly on beats 5 and 6.
- Three non-SOF beats before SOF -> all three accepted with m_axis_tvalid=0; counting starts at the SOF beat.
- m_axis_tready low for 5 cycles at beat 2 -> s_axis_tready=0 during the stall; hlocation holds at 2; total beats still 8.
- tlast at beat 2, then tuser at beat 5 -> err=2'b11 and beat 5 counts as (0,0); reset=1 for 1 cycle -> IDLE, err=0, hlocation=vlocation=0.
- Assert async reset mid-frame at beat 4 -> all outputs 0 immediately; after release with run=1, the next SOF restarts at (0,0).
